pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
// Pipelined main-control unit for the 5-stage RV32I core. Decodes opcode in ID and carries the
// control bundle through ID/EX, EX/MEM and MEM/WB registers, presenting each field at its stage.
// Detects load-use hazards, inserts bubbles, and honours branch flush and an external pipeline hold.
// PARAMETERS
// OPCODE_W  7  opcode width (RV32I inst[6:0])
// REG_W     5  register-index width
// ALU_OP_W  3  alu_op width
// PORTS
// clk           in   1         clock, all state updates on rising edge
// reset         in   1         synchronous, active-low reset
// id_valid      in   1         ID holds a real instruction
// opcode        in   OPCODE_W  ID instruction opcode
// rs1, rs2, rd  in   REG_W     ID register indices
// hold          in   1         freeze whole pipeline (e.g. memory wait)
// flush         in   1         branch/jump taken in MEM: kill ID and EX instructions
// stall         out  1         freeze PC and IF/ID (load-use or hold)
// id_illegal    out  1         comb: id_valid and opcode not recognised
// ex_valid, ex_alu_src  out 1; ex_alu_op out ALU_OP_W; ex_rd out REG_W
// mem_valid, mem_rd, mem_wr, mem_brnch, mem_jump  out 1
// wb_valid, wb_reg_wr, wb_mem_to_rgs  out 1; wb_rd out REG_W
// BEHAVIOUR
// - Decode (alu_src,mem_to_rgs,reg_wr,mem_rd,mem_wr,brnch,jump,alu_op,uses_rs1,uses_rs2):
//   R 0110011: 0,0,1,0,0,0,0,010,1,1 | I-ALU 0010011: 1,0,1,0,0,0,0,011,1,0
//   LOAD 0000011: 1,1,1,1,0,0,0,000,1,0 | STORE 0100011: 1,0,0,0,1,0,0,000,1,1
//   BRANCH 1100011: 0,0,0,0,0,1,0,111,1,1 | JAL 1101111: 1,0,1,0,0,0,1,000,0,0
//   JALR 1100111: 1,0,1,0,0,0,1,000,1,0 | LUI 0110111: 1,0,1,0,0,0,0,100,0,0
//   AUIPC 0010111: 1,0,1,0,0,0,0,000,0,0 | other: all 0, id_illegal=id_valid.
// - reg_wr forced 0 when rd==0. Bundle with id_valid=0 is all-zero bubble.
// - Every stage output is 0 when that stage's valid is 0 (outputs never expose stale fields).
// - Latency: ID decode appears on ex_* 1 cycle later, mem_* 2, wb_* 3 (absent stalls).
// - hazard = id_valid & ex_valid & ex.mem_rd & ex_rd!=0 &
//            ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
// - Per-cycle priority: reset > hold > flush > hazard > normal advance.
//   hold: all three registers keep value; stall=1; flush/hazard ignored (requester re-asserts).
//   flush: ID/EX <= bubble, EX/MEM <= bubble, MEM/WB <= EX/MEM; stall=0.
//   hazard: ID/EX <= bubble, EX/MEM and MEM/WB advance; stall=1 (ID instruction retried).
//   normal: ID/EX <= decode, EX/MEM <= ID/EX, MEM/WB <= EX/MEM; stall=0.
// - stall = reset & (hold | (hazard & ~flush)); 0 while reset low.
// - Reset (reset==0 at clk edge): all valids, control fields and rd fields <= 0; mid-flight
//   instructions are discarded, no partial stage survives.
// - Load followed by 2-apart consumer: no stall (forwarding handles it outside this block).
// STRUCTURE
// - pipe_ctrl_pkg: OPCODE_* localparams, alu_op_e enum (ADD=000,RFUNC=010,IFUNC=011,PASSB=100,
//   BR=111), ctrl_t packed struct of decoded fields, CTRL_BUBBLE constant.
// - Sub-module ctrl_decode: combinational opcode -> ctrl_t + uses_rs1/uses_rs2 + illegal.
// - Top: three ctrl_t+valid+rd registers, hazard compare, priority mux.
// TESTING
// - Reset low 2 cycles with id_valid=1 R-type -> all outputs 0, stall 0; release -> ex_valid=1 next edge.
// - Stream R, LOAD x5, STORE -> ex/mem/wb fields match table at +1/+2/+3; wb_mem_to_rgs=1 only for LOAD.
// - LOAD rd=x5 then ADD rs1=x5 -> stall=1 one cycle, ex bubble (ex_valid=0), ADD reaches EX one cycle later.
// - LOAD rd=x0 then ADD rs1=x0 -> no stall; ADDI rd=x0 -> wb_reg_wr=0.
// - BEQ in MEM with flush=1 -> next cycle ex_valid=0, mem_valid=0, wb shows BEQ (wb_reg_wr=0).
// - hold=1 with flush=1 and pending hazard for 3 cycles -> all stage outputs frozen, stall=1; opcode
//   0000000 with id_valid=1 -> id_illegal=1, bundle flows as zeros.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipelined main-control unit: opcodes, ALU op encoding,
// the decoded control bundle and the per-stage register layout.
package pipe_ctrl_pkg;

    localparam int OPCODE_W = 7;
    localparam int REG_W    = 5;
    localparam int ALU_OP_W = 3;

    localparam logic [OPCODE_W-1:0] OPCODE_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPCODE_I_ALU  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPCODE_AUIPC  = 7'b0010111;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 3'b000,
        ALU_RFUNC = 3'b010,
        ALU_IFUNC = 3'b011,
        ALU_PASSB = 3'b100,
        ALU_BR    = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic    alu_src;
        logic    mem_to_rgs;
        logic    reg_wr;
        logic    mem_rd;
        logic    mem_wr;
        logic    brnch;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef struct packed {
        logic             valid;
        ctrl_t            ctrl;
        logic [REG_W-1:0] rd;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational opcode decode into a control bundle plus source-register usage.
// Zero latency; no flow control.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_t               ctrl_o,
    output logic                uses_rs1_o,
    output logic                uses_rs2_o,
    output logic                known_o
);

    always_comb begin
        ctrl_o     = CTRL_BUBBLE;
        uses_rs1_o = 1'b0;
        uses_rs2_o = 1'b0;
        known_o    = 1'b1;
        unique case (opcode_i)
            OPCODE_R: begin
                ctrl_o.reg_wr = 1'b1;
                ctrl_o.alu_op = ALU_RFUNC;
                uses_rs1_o    = 1'b1;
                uses_rs2_o    = 1'b1;
            end
            OPCODE_I_ALU: begin
                ctrl_o.alu_src = 1'b1;
                ctrl_o.reg_wr  = 1'b1;
                ctrl_o.alu_op  = ALU_IFUNC;
                uses_rs1_o     = 1'b1;
            end
            OPCODE_LOAD: begin
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_to_rgs = 1'b1;
                ctrl_o.reg_wr     = 1'b1;
                ctrl_o.mem_rd     = 1'b1;
                ctrl_o.alu_op     = ALU_ADD;
                uses_rs1_o        = 1'b1;
            end
            OPCODE_STORE: begin
                ctrl_o.alu_src = 1'b1;
                ctrl_o.mem_wr  = 1'b1;
                ctrl_o.alu_op  = ALU_ADD;
                uses_rs1_o     = 1'b1;
                uses_rs2_o     = 1'b1;
            end
            OPCODE_BRANCH: begin
                ctrl_o.brnch  = 1'b1;
                ctrl_o.alu_op = ALU_BR;
                uses_rs1_o    = 1'b1;
                uses_rs2_o    = 1'b1;
            end
            OPCODE_JAL: begin
                ctrl_o.alu_src = 1'b1;
                ctrl_o.reg_wr  = 1'b1;
                ctrl_o.jump    = 1'b1;
            end
            OPCODE_JALR: begin
                ctrl_o.alu_src = 1'b1;
                ctrl_o.reg_wr  = 1'b1;
                ctrl_o.jump    = 1'b1;
                uses_rs1_o     = 1'b1;
            end
            OPCODE_LUI: begin
                ctrl_o.alu_src = 1'b1;
                ctrl_o.reg_wr  = 1'b1;
                ctrl_o.alu_op  = ALU_PASSB;
            end
            OPCODE_AUIPC: begin
                ctrl_o.alu_src = 1'b1;
                ctrl_o.reg_wr  = 1'b1;
            end
            default: known_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main control: decode in ID, carry bundle through ID/EX, EX/MEM, MEM/WB.
// Latency 1/2/3 cycles to ex/mem/wb; hold freezes all stages, load-use inserts one bubble.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [REG_W-1:0]    rs1,
    input  logic [REG_W-1:0]    rs2,
    input  logic [REG_W-1:0]    rd,
    input  logic                hold,
    input  logic                flush,
    output logic                stall,
    output logic                id_illegal,
    output logic                ex_valid,
    output logic                ex_alu_src,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [REG_W-1:0]    ex_rd,
    output logic                mem_valid,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                mem_brnch,
    output logic                mem_jump,
    output logic                wb_valid,
    output logic                wb_reg_wr,
    output logic                wb_mem_to_rgs,
    output logic [REG_W-1:0]    wb_rd
);

    ctrl_t  id_ctrl;
    logic   uses_rs1;
    logic   uses_rs2;
    logic   known;
    stage_t id_stage;
    stage_t ex_q, ex_d;
    stage_t mem_q, mem_d;
    stage_t wb_q, wb_d;
    logic   hazard;

    ctrl_decode u_decode (
        .opcode_i   (opcode),
        .ctrl_o     (id_ctrl),
        .uses_rs1_o (uses_rs1),
        .uses_rs2_o (uses_rs2),
        .known_o    (known)
    );

    assign id_illegal = id_valid & ~known;

    // An invalid slot enters the pipe as an all-zero bubble, including rd.
    always_comb begin
        id_stage = STAGE_EMPTY;
        if (id_valid) begin
            id_stage.valid = 1'b1;
            id_stage.ctrl  = id_ctrl;
            id_stage.rd    = rd;
            if (rd == '0) begin
                id_stage.ctrl.reg_wr = 1'b0;
            end
        end
    end

    assign hazard = id_valid & ex_q.valid & ex_q.ctrl.mem_rd & (ex_q.rd != '0) &
                    ((uses_rs1 & (rs1 == ex_q.rd)) | (uses_rs2 & (rs2 == ex_q.rd)));

    assign stall = reset & (hold | (hazard & ~flush));

    always_comb begin
        ex_d  = id_stage;
        mem_d = ex_q;
        wb_d  = mem_q;
        if (hold) begin
            ex_d  = ex_q;
            mem_d = mem_q;
            wb_d  = wb_q;
        end else if (flush) begin
            ex_d  = STAGE_EMPTY;
            mem_d = STAGE_EMPTY;
        end else if (hazard) begin
            ex_d  = STAGE_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q  <= STAGE_EMPTY;
            mem_q <= STAGE_EMPTY;
            wb_q  <= STAGE_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // Fields are gated by their stage valid so no stale value is ever exposed.
    assign ex_valid      = ex_q.valid;
    assign ex_alu_src    = ex_q.valid & ex_q.ctrl.alu_src;
    assign ex_alu_op     = ex_q.valid ? ex_q.ctrl.alu_op : '0;
    assign ex_rd         = ex_q.valid ? ex_q.rd : '0;
    assign mem_valid     = mem_q.valid;
    assign mem_rd        = mem_q.valid & mem_q.ctrl.mem_rd;
    assign mem_wr        = mem_q.valid & mem_q.ctrl.mem_wr;
    assign mem_brnch     = mem_q.valid & mem_q.ctrl.brnch;
    assign mem_jump      = mem_q.valid & mem_q.ctrl.jump;
    assign wb_valid      = wb_q.valid;
    assign wb_reg_wr     = wb_q.valid & wb_q.ctrl.reg_wr;
    assign wb_mem_to_rgs = wb_q.valid & wb_q.ctrl.mem_to_rgs;
    assign wb_rd         = wb_q.valid ? wb_q.rd : '0;

    logic unused_wb;
    assign unused_wb = ^{wb_q.ctrl.alu_src, wb_q.ctrl.mem_rd, wb_q.ctrl.mem_wr,
                         wb_q.ctrl.brnch, wb_q.ctrl.jump, wb_q.ctrl.alu_op};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: reset, streaming latency, load-use, x0, flush, hold, illegal.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 1'b0;
    logic [6:0] opcode = '0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       hold = 1'b0, flush = 1'b0;
    logic       stall, id_illegal;
    logic       ex_valid, ex_alu_src;
    logic [2:0] ex_alu_op;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_rd, mem_wr, mem_brnch, mem_jump;
    logic       wb_valid, wb_reg_wr, wb_mem_to_rgs;
    logic [4:0] wb_rd;

    int total = 0;
    int passed = 0;

    pipe_ctrl_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode),
        .rs1(rs1), .rs2(rs2), .rd(rd), .hold(hold), .flush(flush),
        .stall(stall), .id_illegal(id_illegal),
        .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_brnch(mem_brnch), .mem_jump(mem_jump),
        .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_mem_to_rgs(wb_mem_to_rgs), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [6:0] op,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        id_valid = v; opcode = op; rs1 = s1; rs2 = s2; rd = d;
        #1;
    endtask

    task automatic drain();
        issue(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        issue(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
        step(); step();
        total++; if ({ex_valid, mem_valid, wb_valid} !== 3'b000) $display("FAIL reset_valids got %b exp 000", {ex_valid, mem_valid, wb_valid}); else passed++;
        total++; if ({ex_alu_src, ex_alu_op, ex_rd} !== 9'd0) $display("FAIL reset_ex_fields got %h exp 0", {ex_alu_src, ex_alu_op, ex_rd}); else passed++;
        total++; if ({mem_rd, mem_wr, mem_brnch, mem_jump, wb_reg_wr, wb_mem_to_rgs, wb_rd} !== 11'd0) $display("FAIL reset_mem_wb_fields got %h exp 0", {mem_rd, mem_wr, mem_brnch, mem_jump, wb_reg_wr, wb_mem_to_rgs, wb_rd}); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else passed++;
        reset = 1'b1;
        step();
        total++; if ({ex_valid, ex_alu_src, ex_alu_op, ex_rd} !== {1'b1, 1'b0, 3'b010, 5'd3}) $display("FAIL reset_release_ex got %h exp %h", {ex_valid, ex_alu_src, ex_alu_op, ex_rd}, {1'b1, 1'b0, 3'b010, 5'd3}); else passed++;
        drain();
    endtask

    task automatic test_stream();
        issue(1'b1, OP_R, 5'd2, 5'd3, 5'd1);
        step();
        total++; if ({ex_valid, ex_alu_src, ex_alu_op, ex_rd} !== {1'b1, 1'b0, 3'b010, 5'd1}) $display("FAIL stream_ex_r got %h exp %h", {ex_valid, ex_alu_src, ex_alu_op, ex_rd}, {1'b1, 1'b0, 3'b010, 5'd1}); else passed++;
        issue(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5);
        step();
        total++; if ({ex_valid, ex_alu_src, ex_alu_op, ex_rd} !== {1'b1, 1'b1, 3'b000, 5'd5}) $display("FAIL stream_ex_load got %h exp %h", {ex_valid, ex_alu_src, ex_alu_op, ex_rd}, {1'b1, 1'b1, 3'b000, 5'd5}); else passed++;
        total++; if ({mem_valid, mem_rd, mem_wr, mem_brnch, mem_jump} !== 5'b10000) $display("FAIL stream_mem_r got %b exp 10000", {mem_valid, mem_rd, mem_wr, mem_brnch, mem_jump}); else passed++;
        issue(1'b1, OP_STORE, 5'd6, 5'd7, 5'd0);
        total++; if (stall !== 1'b0) $display("FAIL stream_store_no_stall got %b exp 0", stall); else passed++;
        step();
        total++; if ({ex_valid, ex_alu_src, ex_alu_op, ex_rd} !== {1'b1, 1'b1, 3'b000, 5'd0}) $display("FAIL stream_ex_store got %h exp %h", {ex_valid, ex_alu_src, ex_alu_op, ex_rd}, {1'b1, 1'b1, 3'b000, 5'd0}); else passed++;
        total++; if ({mem_valid, mem_rd, mem_wr} !== 3'b110) $display("FAIL stream_mem_load got %b exp 110", {mem_valid, mem_rd, mem_wr}); else passed++;
        total++; if ({wb_valid, wb_reg_wr, wb_mem_to_rgs, wb_rd} !== {3'b110, 5'd1}) $display("FAIL stream_wb_r got %h exp %h", {wb_valid, wb_reg_wr, wb_mem_to_rgs, wb_rd}, {3'b110, 5'd1}); else passed++;
        issue(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        step();
        total++; if ({ex_valid, mem_valid, mem_rd, mem_wr} !== 4'b0101) $display("FAIL stream_mem_store got %b exp 0101", {ex_valid, mem_valid, mem_rd, mem_wr}); else passed++;
        total++; if ({wb_valid, wb_reg_wr, wb_mem_to_rgs, wb_rd} !== {3'b111, 5'd5}) $display("FAIL stream_wb_load got %h exp %h", {wb_valid, wb_reg_wr, wb_mem_to_rgs, wb_rd}, {3'b111, 5'd5}); else passed++;
        step();
        total++; if ({wb_valid, wb_reg_wr, wb_mem_to_rgs, wb_rd} !== {3'b100, 5'd0}) $display("FAIL stream_wb_store got %h exp %h", {wb_valid, wb_reg_wr, wb_mem_to_rgs, wb_rd}, {3'b100, 5'd0}); else passed++;
        drain();
    endtask

    task automatic test_load_use();
        issue(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5);
        step();
        issue(1'b1, OP_R, 5'd5, 5'd2, 5'd6);
        total++; if (stall !== 1'b1) $display("FAIL loaduse_stall got %b exp 1", stall); else passed++;
        step();
        total++; if ({ex_valid, mem_valid, mem_rd} !== 3'b011) $display("FAIL loaduse_bubble got %b exp 011", {ex_valid, mem_valid, mem_rd}); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL loaduse_stall_release got %b exp 0", stall); else passed++;
        step();
        total++; if ({ex_valid, ex_alu_op, ex_rd} !== {1'b1, 3'b010, 5'd6}) $display("FAIL loaduse_add_ex got %h exp %h", {ex_valid, ex_alu_op, ex_rd}, {1'b1, 3'b010, 5'd6}); else passed++;
        // consumer two behind a load must not stall
        issue(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd7);
        step();
        issue(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        step();
        issue(1'b1, OP_R, 5'd3, 5'd7, 5'd8);
        total++; if (stall !== 1'b0) $display("FAIL loaduse_two_apart got %b exp 0", stall); else passed++;
        drain();
    endtask

    task automatic test_x0();
        issue(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd0);
        step();
        issue(1'b1, OP_R, 5'd0, 5'd0, 5'd4);
        total++; if (stall !== 1'b0) $display("FAIL x0_no_stall got %b exp 0", stall); else passed++;
        step();
        total++; if ({ex_valid, ex_rd} !== {1'b1, 5'd4}) $display("FAIL x0_add_ex got %h exp %h", {ex_valid, ex_rd}, {1'b1, 5'd4}); else passed++;
        issue(1'b1, OP_IALU, 5'd1, 5'd0, 5'd0);
        step();
        total++; if ({ex_alu_src, ex_alu_op} !== 4'b1011) $display("FAIL x0_addi_ex got %b exp 1011", {ex_alu_src, ex_alu_op}); else passed++;
        issue(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        step(); step();
        total++; if ({wb_valid, wb_reg_wr, wb_rd} !== {2'b10, 5'd0}) $display("FAIL x0_addi_wb got %h exp %h", {wb_valid, wb_reg_wr, wb_rd}, {2'b10, 5'd0}); else passed++;
        drain();
    endtask

    task automatic test_flush();
        issue(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0);
        step();
        issue(1'b1, OP_R, 5'd3, 5'd4, 5'd8);
        step();
        total++; if ({mem_valid, mem_brnch} !== 2'b11) $display("FAIL flush_beq_mem got %b exp 11", {mem_valid, mem_brnch}); else passed++;
        issue(1'b1, OP_R, 5'd3, 5'd4, 5'd9);
        flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL flush_stall got %b exp 0", stall); else passed++;
        step();
        flush = 1'b0;
        total++; if ({ex_valid, mem_valid} !== 2'b00) $display("FAIL flush_killed got %b exp 00", {ex_valid, mem_valid}); else passed++;
        total++; if ({wb_valid, wb_reg_wr, wb_mem_to_rgs} !== 3'b100) $display("FAIL flush_wb_beq got %b exp 100", {wb_valid, wb_reg_wr, wb_mem_to_rgs}); else passed++;
        drain();
    endtask

    task automatic test_hold_illegal();
        issue(1'b1, OP_R, 5'd2, 5'd3, 5'd1);
        step();
        issue(1'b1, OP_IALU, 5'd3, 5'd0, 5'd2);
        step();
        issue(1'b1, OP_LOAD, 5'd3, 5'd0, 5'd5);
        step();
        issue(1'b1, OP_R, 5'd5, 5'd2, 5'd6);
        hold = 1'b1; flush = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (stall !== 1'b1) $display("FAIL hold_stall[%0d] got %b exp 1", i, stall); else passed++;
            step();
            total++; if ({ex_valid, ex_alu_src, ex_rd, mem_valid, mem_rd, wb_valid, wb_reg_wr, wb_rd} !== {2'b11, 5'd5, 2'b10, 2'b11, 5'd1}) $display("FAIL hold_frozen[%0d] got %h exp %h", i, {ex_valid, ex_alu_src, ex_rd, mem_valid, mem_rd, wb_valid, wb_reg_wr, wb_rd}, {2'b11, 5'd5, 2'b10, 2'b11, 5'd1}); else passed++;
        end
        hold = 1'b0; flush = 1'b0;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL hold_release_hazard got %b exp 1", stall); else passed++;
        step();
        total++; if ({ex_valid, mem_valid, mem_rd, wb_valid, wb_rd} !== {3'b011, 1'b1, 5'd2}) $display("FAIL hold_release_advance got %h exp %h", {ex_valid, mem_valid, mem_rd, wb_valid, wb_rd}, {3'b011, 1'b1, 5'd2}); else passed++;
        issue(1'b1, 7'b0000000, 5'd1, 5'd2, 5'd3);
        total++; if (id_illegal !== 1'b1) $display("FAIL illegal_flag got %b exp 1", id_illegal); else passed++;
        step();
        issue(1'b0, 7'b0000000, 5'd0, 5'd0, 5'd0);
        total++; if (id_illegal !== 1'b0) $display("FAIL illegal_invalid got %b exp 0", id_illegal); else passed++;
        total++; if ({ex_alu_src, ex_alu_op} !== 4'b0000) $display("FAIL illegal_ex_zero got %b exp 0000", {ex_alu_src, ex_alu_op}); else passed++;
        step();
        total++; if ({mem_rd, mem_wr, mem_brnch, mem_jump} !== 4'b0000) $display("FAIL illegal_mem_zero got %b exp 0000", {mem_rd, mem_wr, mem_brnch, mem_jump}); else passed++;
        step();
        total++; if ({wb_reg_wr, wb_mem_to_rgs} !== 2'b00) $display("FAIL illegal_wb_zero got %b exp 00", {wb_reg_wr, wb_mem_to_rgs}); else passed++;
        drain();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_load_use();
        test_x0();
        test_flush();
        test_hold_illegal();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
